// File: rtl/axil_slave_regbank.sv
// AXI4-Lite register bank: reg 0 is a read-only ID, regs 1..NUM_REGS-1 are byte-strobed RW; one write and one read in flight.
// B/R valid one cycle after the (last) address/data handshake and held until ready; define AXIL_REGBANK_SLVERR_EN for SLVERR on out-of-range.
module axil_slave_regbank #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA3B1_0001
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int SEL_W  = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE    = 2'd0;
  localparam logic [1:0] W_HAVE_AW = 2'd1;
  localparam logic [1:0] W_HAVE_W  = 2'd2;
  localparam logic [1:0] W_RESP    = 2'd3;
  localparam logic       R_IDLE    = 1'b0;
  localparam logic       R_RESP    = 1'b1;

  logic [1:0]            w_state_q, w_state_d;
  logic                  r_state_q, r_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

  logic [IDX_W-1:0]      aw_idx, ar_idx, commit_idx;
  logic [SEL_W-1:0]      commit_sel, ar_sel;
  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit_en, commit_in_range, ar_in_range;
  logic [DATA_WIDTH-1:0] commit_data, rd_val;
  logic [STRB_W-1:0]     commit_strb;
  logic [1:0]            w_resp, r_resp;
  logic                  unused_addr_bits;

  assign aw_idx = s_axil_awaddr[ADDR_WIDTH-1:2];
  assign ar_idx = s_axil_araddr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = &{1'b0, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

  assign aw_hs = s_axil_awvalid && awready_q;
  assign w_hs  = s_axil_wvalid && wready_q;
  assign ar_hs = s_axil_arvalid && arready_q;

  assign commit_in_range = (commit_idx < IDX_W'(NUM_REGS));
  assign commit_sel      = commit_idx[SEL_W-1:0];
  assign ar_in_range     = (ar_idx < IDX_W'(NUM_REGS));
  assign ar_sel          = ar_idx[SEL_W-1:0];

`ifdef AXIL_REGBANK_SLVERR_EN
  assign w_resp = commit_in_range ? RESP_OKAY : RESP_SLVERR;
  assign r_resp = ar_in_range ? RESP_OKAY : RESP_SLVERR;
`else
  assign w_resp = RESP_OKAY;
  assign r_resp = RESP_OKAY;
`endif

  // Register 0 is never stored; reads of it return the ID constant.
  assign rd_val = !ar_in_range    ? '0 :
                  (ar_sel == '0)  ? ID_VALUE : regs_q[ar_sel];

  always_comb begin
    w_state_d   = w_state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    aw_idx_d    = aw_idx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    commit_en   = 1'b0;
    commit_idx  = aw_idx_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b1;
        if (aw_hs && w_hs) begin
          commit_en   = 1'b1;
          commit_idx  = aw_idx;
          commit_data = s_axil_wdata;
          commit_strb = s_axil_wstrb;
        end else if (aw_hs) begin
          aw_idx_d  = aw_idx;
          awready_d = 1'b0;
          w_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d   = s_axil_wdata;
          wstrb_d   = s_axil_wstrb;
          wready_d  = 1'b0;
          w_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit_en   = 1'b1;
          commit_data = s_axil_wdata;
          commit_strb = s_axil_wstrb;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit_en  = 1'b1;
          commit_idx = aw_idx;
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit_en) begin
      awready_d = 1'b0;
      wready_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = w_resp;
      w_state_d = W_RESP;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_val;
          rresp_d   = r_resp;
          r_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axil_rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      aw_idx_q  <= aw_idx_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit_en && commit_in_range && (commit_sel != '0)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (commit_strb[b]) regs_q[commit_sel][8*b +: 8] <= commit_data[8*b +: 8];
      end
    end
  end

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = wready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_slave_regbank.sv
// Directed bench for axil_slave_regbank: stimulus pushes expected B/R responses into queues, a negedge monitor pops and compares.
module tb_axil_slave_regbank;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;

  always #5 clock = ~clock;

  axil_slave_regbank dut (
    .clock(clock), .reset(reset),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
    .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready)
  );

`ifdef AXIL_REGBANK_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [1:0]  b_q[$];
  rexp_t       r_q[$];
  logic [31:0] exp_regs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && s_axil_bvalid && s_axil_bready) begin
      if (b_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected: bvalid with bresp=%0b but no response expected", s_axil_bresp);
      end else begin
        check("bresp", 32'(s_axil_bresp), 32'(b_q.pop_front()));
      end
    end
    if (!reset && s_axil_rvalid && s_axil_rready) begin
      if (r_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL r_unexpected: rvalid with rdata=0x%08h but no response expected", s_axil_rdata);
      end else begin
        rexp_t e;
        e = r_q.pop_front();
        check("rdata", s_axil_rdata, e.data);
        check("rresp", 32'(s_axil_rresp), 32'(e.resp));
      end
    end
  end

  function automatic logic hs(input int ch);
    case (ch)
      0:       return s_axil_awvalid && s_axil_awready;
      1:       return s_axil_wvalid && s_axil_wready;
      2:       return s_axil_arvalid && s_axil_arready;
      3:       return s_axil_bvalid && s_axil_bready;
      default: return s_axil_rvalid && s_axil_rready;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the handshake edge, n = cycles waited.
  task automatic wait_hs(input int ch, input string name, output int n);
    n = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clock);
      if (hs(ch)) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: no handshake within 64 cycles", name);
    end
    @(posedge clock); #1;
  endtask

  task automatic write_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] exp_resp);
    int n;
    b_q.push_back(exp_resp);
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    wait_hs(0, "aw_w", n);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    wait_hs(3, "b", n);
    check("b_latency", n, 1);
  endtask

  task automatic read(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    int n;
    r_q.push_back('{resp: exp_r, data: exp_d});
    s_axil_araddr = a; s_axil_arvalid = 1'b1;
    wait_hs(2, "ar", n);
    s_axil_arvalid = 1'b0;
    wait_hs(4, "r", n);
    check("r_latency", n, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    s_axil_awaddr = '0; s_axil_awvalid = 1'b0; s_axil_wdata = '0; s_axil_wstrb = '0;
    s_axil_wvalid = 1'b0; s_axil_bready = 1'b1; s_axil_araddr = '0; s_axil_arvalid = 1'b0;
    s_axil_rready = 1'b1;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    check("rst_ready", {s_axil_awready, s_axil_wready, s_axil_arready}, 0);
    check("rst_valid", {s_axil_bvalid, s_axil_rvalid}, 0);
    check("rst_resp", {s_axil_bresp, s_axil_rresp}, 0);
    check("rst_rdata", s_axil_rdata, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("ready_before_first_edge", {s_axil_awready, s_axil_wready, s_axil_arready}, 0);
    @(posedge clock); #1;
    check("ready_after_first_edge", {s_axil_awready, s_axil_wready, s_axil_arready}, 3'b111);

    // 1: simultaneous AW/W, then read back
    write_both(32'h4, 32'hDEADBEEF, 4'hF, 2'b00);
    exp_regs[1] = 32'hDEADBEEF;
    check("aw_ready_after_b", {s_axil_awready, s_axil_wready}, 2'b11);
    read(32'h4, 32'hDEADBEEF, 2'b00);
    read(32'h7, 32'hDEADBEEF, 2'b00);

    // 2a: AW first, W three cycles later
    b_q.push_back(2'b00);
    s_axil_awaddr = 32'h8; s_axil_awvalid = 1'b1;
    wait_hs(0, "aw_first", n);
    s_axil_awvalid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("awready_low_wait_w", s_axil_awready, 0);
      check("bvalid_low_wait_w", s_axil_bvalid, 0);
    end
    @(posedge clock); #1;
    s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    wait_hs(1, "w_second", n);
    s_axil_wvalid = 1'b0;
    wait_hs(3, "b_aw_first", n);
    check("b_latency_aw_first", n, 1);
    exp_regs[2] = 32'h12345678;
    read(32'h8, 32'h12345678, 2'b00);

    // 2b: W first, AW later
    b_q.push_back(2'b00);
    s_axil_wdata = 32'h12345678; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    wait_hs(1, "w_first", n);
    s_axil_wvalid = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("wready_low_wait_aw", s_axil_wready, 0);
    end
    @(posedge clock); #1;
    s_axil_awaddr = 32'h8; s_axil_awvalid = 1'b1;
    wait_hs(0, "aw_second", n);
    s_axil_awvalid = 1'b0;
    wait_hs(3, "b_w_first", n);
    check("b_latency_w_first", n, 1);
    read(32'h8, 32'h12345678, 2'b00);

    // 3: partial strobes and the read-only ID register
    write_both(32'h8, 32'hAABBCCDD, 4'b0101, 2'b00);
    exp_regs[2] = 32'h12BB56DD;
    read(32'h8, 32'h12BB56DD, 2'b00);
    write_both(32'h0, 32'hFFFFFFFF, 4'hF, 2'b00);
    read(32'h0, 32'hA3B10001, 2'b00);

    // 4: B and R backpressure
    s_axil_bready = 1'b0;
    b_q.push_back(2'b00);
    s_axil_awaddr = 32'h10; s_axil_wdata = 32'h0BADF00D; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    wait_hs(0, "aw_bp", n);
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    exp_regs[4] = 32'h0BADF00D;
    repeat (5) begin
      @(negedge clock);
      check("b_held", {s_axil_bvalid, s_axil_bresp}, 3'b100);
      check("ready_low_b_held", {s_axil_awready, s_axil_wready}, 0);
    end
    @(posedge clock); #1;
    s_axil_bready = 1'b1;
    wait_hs(3, "b_bp", n);
    s_axil_rready = 1'b0;
    r_q.push_back('{resp: 2'b00, data: 32'h0BADF00D});
    s_axil_araddr = 32'h10; s_axil_arvalid = 1'b1;
    wait_hs(2, "ar_bp", n);
    s_axil_arvalid = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("r_held_data", s_axil_rdata, 32'h0BADF00D);
      check("r_held_ctl", {s_axil_rvalid, s_axil_arready}, 2'b10);
    end
    @(posedge clock); #1;
    s_axil_rready = 1'b1;
    wait_hs(4, "r_bp", n);

    // 5: out-of-range write and read, then sweep the bank
    write_both(32'h40, 32'h1, 4'hF, OOR_RESP);
    read(32'h40, 32'h0, OOR_RESP);
    for (int i = 1; i < 16; i++) read(32'(i * 4), exp_regs[i], 2'b00);

    // 6: reset between AW and W aborts the write
    s_axil_awaddr = 32'hC; s_axil_awvalid = 1'b1;
    wait_hs(0, "aw_abort", n);
    s_axil_awvalid = 1'b0;
    reset = 1'b1;
    s_axil_wdata = 32'hCAFEF00D; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    s_axil_wvalid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    @(negedge clock);
    check("bvalid_after_abort", s_axil_bvalid, 0);
    @(posedge clock); #1;
    read(32'hC, 32'h0, 2'b00);
    read(32'h4, 32'h0, 2'b00);
    write_both(32'hC, 32'h00000055, 4'hF, 2'b00);
    read(32'hC, 32'h00000055, 2'b00);

    repeat (2) @(posedge clock);
    check("b_queue_drained", b_q.size(), 0);
    check("r_queue_drained", r_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

endmodule
